mmio_console: RTL and testbench

Memory-mapped output port on the single-cycle MIPS data bus. CPU stores to a fixed address window push 32-bit words into a small FIFO, which drains to a host/testbench over a valid/ready stream. The block decodes the same `memwrite`/`dataadr`/`writedata` store bus that data memory sees, giving programs a console/result channel and a status register they can poll. It sits beside `dmem` inside `computer`.

---
 rtl/mmio_console.sv | 98 +++++++++
 tb/tb_mmio_console.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// Memory-mapped console: CPU stores to a fixed window feed a small FIFO drained over valid/ready.
// Optional HALT register enabled by defining MMIO_CONSOLE_HALT_EN.
module mmio_console #(
    parameter int              n     = 32,
    parameter int              DEPTH = 4,
    parameter logic [n-1:0]    BASE  = 32'h0000_0100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [n-1:0] dataadr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         hit,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    input  logic         out_ready,
    output logic         overflow,
    output logic         halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [n-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_sel_data;
    logic w_sel_stat;
    logic w_sel_ctrl;
    logic w_sel_halt;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_accept;

    assign w_sel_data = (dataadr == BASE);
    assign w_sel_stat = (dataadr == BASE + n'(4));
    assign w_sel_ctrl = (dataadr == BASE + n'(8));
`ifdef MMIO_CONSOLE_HALT_EN
    assign w_sel_halt = (dataadr == BASE + n'(12));
`else
    assign w_sel_halt = 1'b0;
`endif

    assign hit      = w_sel_data | w_sel_stat | w_sel_ctrl | w_sel_halt;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = memwrite & w_sel_data;
    assign w_pop    = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_accept = w_push & (~w_full | w_pop);

    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd];
    assign overflow  = r_overflow;
    assign readdata  = w_sel_stat ? {{(n-CW-3){1'b0}}, r_overflow, w_full, w_empty, r_count} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr] <= writedata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set has priority over a CTRL clear in the same cycle.
            if (w_push && w_full && !w_pop)      r_overflow <= 1'b1;
            else if (memwrite && w_sel_ctrl)     r_overflow <= 1'b0;
        end
    end

`ifdef MMIO_CONSOLE_HALT_EN
    logic r_halt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      r_halt <= 1'b0;
        else if (memwrite && w_sel_halt) r_halt <= 1'b1;
    end
    assign halt = r_halt;
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_console.sv
// Scoreboard bench for mmio_console: expected words queued on store, popped on drain.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        halt;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    logic        movf = 1'b0;
    logic        mhalt = 1'b0;

    mmio_console #(.n(32), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .hit(hit),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow), .halt(halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [2:0] c;
        c = 3'(q.size());
        return {26'b0, movf, q.size() == DEPTH, q.size() == 0, c};
    endfunction

    // One clock: drive at negedge, check valid/data against the scoreboard, update model, advance.
    task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        logic        mpop;
        logic        full_pre;
        logic        set;
        logic [31:0] exp;
        memwrite = we; dataadr = adr; writedata = wd; out_ready = rdy;
        #1;
        tests++;
        if (out_valid !== (q.size() != 0)) begin
            fails++;
            $display("FAIL valid: got %b want %b", out_valid, q.size() != 0);
        end
        full_pre = (q.size() == DEPTH);
        mpop = rdy && (q.size() != 0);
        if (mpop) begin
            exp = q.pop_front();
            tests++;
            if (out_data !== exp) begin
                fails++;
                $display("FAIL pop_data: got %h want %h", out_data, exp);
            end
        end
        set = 1'b0;
        if (we && adr == BASE) begin
            if (full_pre && !mpop) set = 1'b1;
            else q.push_back(wd);
        end
        if (set) movf = 1'b1;
        else if (we && adr == BASE + 32'd8) movf = 1'b0;
`ifdef MMIO_CONSOLE_HALT_EN
        if (we && adr == BASE + 32'd12) mhalt = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);
        memwrite = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        dataadr = BASE + 32'd4;
        #1;
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || halt !== 1'b0 || out_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b o=%b h=%b d=%h want 0 0 0 0", out_valid, overflow, halt, out_data);
        end
        tests++;
        if (readdata !== 32'h8) begin
            fails++;
            $display("FAIL reset_status: got %h want %h", readdata, 32'h8);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        cycle(1'b1, BASE, 32'h96, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h96) begin
            fails++;
            $display("FAIL single_head: got v=%b d=%h want 1 96", out_valid, out_data);
        end
        dataadr = BASE + 32'd4;
        #1;
        tests++;
        if (readdata !== 32'h1 || readdata !== exp_status()) begin
            fails++;
            $display("FAIL single_status: got %h want %h", readdata, 32'h1);
        end
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) cycle(1'b1, BASE, 32'(i), 1'b0);
        dataadr = BASE + 32'd4;
        #1;
        tests++;
        if (readdata !== 32'h34 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_status: got %h ovf=%b want 34 1", readdata, overflow);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_ctrl();
        cycle(1'b1, BASE + 32'd8, 32'h0, 1'b0);
        dataadr = BASE + 32'd4;
        #1;
        tests++;
        if (overflow !== 1'b0 || readdata !== 32'h8) begin
            fails++;
            $display("FAIL ctrl_clear: got ovf=%b st=%h want 0 8", overflow, readdata);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, BASE, 32'h50 + 32'(i), 1'b0);
        cycle(1'b1, BASE, 32'h5F, 1'b0);
        cycle(1'b1, BASE + 32'd8, 32'h0, 1'b0);
        cycle(1'b1, BASE, 32'h5E, 1'b0);
        tests++;
        if (overflow !== 1'b1 || overflow !== movf) begin
            fails++;
            $display("FAIL ctrl_reset_again: got %b want 1", overflow);
        end
        cycle(1'b1, BASE + 32'd8, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_wrap();
        cycle(1'b1, BASE, 32'h61, 1'b0);
        cycle(1'b1, BASE, 32'h62, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b1, BASE, 32'h70 + 32'(i), 1'b0);
        cycle(1'b1, BASE, 32'hA, 1'b1);
        dataadr = BASE + 32'd4;
        #1;
        tests++;
        if (readdata !== 32'h14 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_status: got %h ovf=%b want 14 0", readdata, overflow);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL wrap_drain: got v=%b left=%0d want 0 0", out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) cycle(1'b1, BASE, $urandom, 1'b1);
        tests++;
        if (out_valid !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stream: got v=%b ovf=%b want 1 0", out_valid, overflow);
        end
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_hit();
        logic [31:0] adrs [6];
        logic        want [6];
        adrs = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd2, BASE + 32'd16};
`ifdef MMIO_CONSOLE_HALT_EN
        want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        want = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            dataadr = adrs[i];
            #1;
            tests++;
            if (hit !== want[i]) begin
                fails++;
                $display("FAIL hit_%h: got %b want %b", adrs[i], hit, want[i]);
            end
        end
        cycle(1'b1, BASE + 32'd1, 32'hDEAD, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_push: got %b want 0", out_valid);
        end
    endtask

    task automatic test_halt();
        cycle(1'b1, BASE + 32'd12, 32'h1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        tests++;
`ifdef MMIO_CONSOLE_HALT_EN
        if (halt !== 1'b1 || halt !== mhalt) begin
            fails++;
            $display("FAIL halt_set: got %b want 1", halt);
        end
`else
        if (halt !== 1'b0 || halt !== mhalt) begin
            fails++;
            $display("FAIL halt_tied: got %b want 0", halt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, BASE, 32'hC0 + 32'(i), 1'b0);
        cycle(1'b1, BASE, 32'hC3, 1'b0);
        cycle(1'b1, BASE, 32'hC4, 1'b0);
        dataadr = BASE + 32'd4;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        movf = 1'b0;
        mhalt = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || halt !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%b o=%b h=%b want 0 0 0", out_valid, overflow, halt);
        end
        tests++;
        if (readdata !== 32'h8) begin
            fails++;
            $display("FAIL midreset_status: got %h want 8", readdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cycle(1'b1, BASE, 32'h77, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_ctrl();
        test_wrap();
        test_back_to_back();
        test_hit();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
